// File: rtl/usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rx_deserializer
//  Purpose  : USB receive stage behind the NRZI decoder. Detects SYNC, drops
//             stuffed bits and assembles LSB-first bytes. Reports each byte,
//             a clean packet end, or a framing/stuffing/overflow error to the
//             packet layer.
//  Ports    : clk, n_rst (async, active-low)
//             d_in, bit_valid, eop       - decoded bit, strobe, SE0 level
//             rx_data / rx_data_valid    - completed byte and its pulse
//             rx_active                  - high while inside a packet
//             rx_done / rx_error         - end-of-packet / abort pulses
//             rx_err_code                - 01 stuff, 10 misaligned EOP,
//                                          11 overflow (held)
//             rx_byte_cnt                - bytes delivered in this packet
//  Revision : 1.0 - initial release
// ============================================================================
module usb_rx_deserializer #(
  parameter int MAX_BYTES = 67
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_in,
  input  logic       bit_valid,
  input  logic       eop,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_done,
  output logic       rx_error,
  output logic [1:0] rx_err_code,
  output logic [6:0] rx_byte_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    WAIT_EOP  = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  localparam logic [2:0] c_SYNC_ZEROS = 3'd3;
  localparam logic [2:0] c_ONES_STUFF = 3'd6;
  localparam logic [6:0] c_MAX_BYTES  = 7'(MAX_BYTES);

  state_t     r_state,   w_state;
  logic [2:0] r_zero_cnt, w_zero_cnt;
  logic [2:0] r_ones_cnt, w_ones_cnt;
  logic [3:0] r_bit_cnt,  w_bit_cnt;
  logic [7:0] r_shreg,    w_shreg;
  logic [7:0] r_rx_data,  w_rx_data;
  logic       r_rx_data_valid, w_rx_data_valid;
  logic       r_rx_active, w_rx_active;
  logic       r_rx_done,   w_rx_done;
  logic       r_rx_error,  w_rx_error;
  logic [1:0] r_rx_err_code, w_rx_err_code;
  logic [6:0] r_rx_byte_cnt, w_rx_byte_cnt;

  // Shift register with the current bit inserted, and the incremented count
  logic [7:0] w_ins;
  logic [3:0] w_bit_inc;

  always_comb begin
    w_state         = r_state;
    w_zero_cnt      = r_zero_cnt;
    w_ones_cnt      = r_ones_cnt;
    w_bit_cnt       = r_bit_cnt;
    w_shreg         = r_shreg;
    w_rx_data       = r_rx_data;
    w_rx_data_valid = 1'b0;
    w_rx_done       = 1'b0;
    w_rx_error      = 1'b0;
    w_rx_err_code   = r_rx_err_code;
    w_rx_byte_cnt   = r_rx_byte_cnt;
    w_ins           = r_shreg;
    w_ins[r_bit_cnt[2:0]] = d_in;
    w_bit_inc       = r_bit_cnt + 4'd1;

    case (r_state)
      IDLE: begin
        if (eop) begin
          w_zero_cnt = 3'd0;
        end else if (bit_valid) begin
          if (!d_in) begin
            if (r_zero_cnt != 3'd7) w_zero_cnt = r_zero_cnt + 3'd1;
          end else if (r_zero_cnt >= c_SYNC_ZEROS) begin
            // The SYNC's closing 1 already counts toward the stuffing run
            w_state       = DATA;
            w_ones_cnt    = 3'd1;
            w_bit_cnt     = 4'd0;
            w_rx_byte_cnt = 7'd0;
            w_zero_cnt    = 3'd0;
          end else begin
            w_zero_cnt = 3'd0;
          end
        end
      end

      DATA: begin
        // EOP has priority; a bit arriving with it is dropped
        if (eop) begin
          if (r_bit_cnt == 4'd0) begin
            w_rx_done = 1'b1;
          end else begin
            w_rx_error    = 1'b1;
            w_rx_err_code = 2'b10;
          end
          w_state = WAIT_IDLE;
        end else if (bit_valid) begin
          if (r_ones_cnt == c_ONES_STUFF) begin
            if (!d_in) begin
              w_ones_cnt = 3'd0;
            end else begin
              w_rx_error    = 1'b1;
              w_rx_err_code = 2'b01;
              w_state       = WAIT_EOP;
            end
          end else begin
            w_ones_cnt = d_in ? (r_ones_cnt + 3'd1) : 3'd0;
            if (w_bit_inc == 4'd8) begin
              w_bit_cnt = 4'd0;
              if (r_rx_byte_cnt == c_MAX_BYTES) begin
                w_rx_error    = 1'b1;
                w_rx_err_code = 2'b11;
                w_state       = WAIT_EOP;
              end else begin
                w_rx_data       = w_ins;
                w_rx_data_valid = 1'b1;
                w_rx_byte_cnt   = r_rx_byte_cnt + 7'd1;
              end
            end else begin
              w_shreg   = w_ins;
              w_bit_cnt = w_bit_inc;
            end
          end
        end
      end

      WAIT_EOP: begin
        if (eop) w_state = WAIT_IDLE;
      end

      WAIT_IDLE: begin
        if (!eop) begin
          w_state    = IDLE;
          w_zero_cnt = 3'd0;
        end
      end

      default: w_state = IDLE;
    endcase

    w_rx_active = (w_state == DATA);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_zero_cnt      <= 3'd0;
      r_ones_cnt      <= 3'd0;
      r_bit_cnt       <= 4'd0;
      r_shreg         <= 8'h00;
      r_rx_data       <= 8'h00;
      r_rx_data_valid <= 1'b0;
      r_rx_active     <= 1'b0;
      r_rx_done       <= 1'b0;
      r_rx_error      <= 1'b0;
      r_rx_err_code   <= 2'b00;
      r_rx_byte_cnt   <= 7'd0;
    end else begin
      r_state         <= w_state;
      r_zero_cnt      <= w_zero_cnt;
      r_ones_cnt      <= w_ones_cnt;
      r_bit_cnt       <= w_bit_cnt;
      r_shreg         <= w_shreg;
      r_rx_data       <= w_rx_data;
      r_rx_data_valid <= w_rx_data_valid;
      r_rx_active     <= w_rx_active;
      r_rx_done       <= w_rx_done;
      r_rx_error      <= w_rx_error;
      r_rx_err_code   <= w_rx_err_code;
      r_rx_byte_cnt   <= w_rx_byte_cnt;
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_rx_data_valid;
  assign rx_active     = r_rx_active;
  assign rx_done       = r_rx_done;
  assign rx_error      = r_rx_error;
  assign rx_err_code   = r_rx_err_code;
  assign rx_byte_cnt   = r_rx_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_rx_deserializer
//  Purpose  : Directed bench for usb_rx_deserializer. Two instances: default
//             MAX_BYTES and MAX_BYTES=2. Expected byte/done/error events are
//             queued by the stimulus and consumed by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_deserializer;

  localparam logic [1:0] c_EV_BYTE = 2'd0;
  localparam logic [1:0] c_EV_DONE = 2'd1;
  localparam logic [1:0] c_EV_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];

  int total  = 0;
  int passed = 0;

  logic clk = 1'b0;
  logic n_rst;
  logic sel;
  logic d, bv, e;

  logic       d_in1, bv1, eop1, d_in2, bv2, eop2;
  logic [7:0] rx_data1, rx_data2;
  logic       rx_data_valid1, rx_data_valid2;
  logic       rx_active1, rx_active2;
  logic       rx_done1, rx_done2;
  logic       rx_error1, rx_error2;
  logic [1:0] rx_err_code1, rx_err_code2;
  logic [6:0] rx_byte_cnt1, rx_byte_cnt2;

  assign d_in1 = sel ? 1'b0 : d;
  assign bv1   = sel ? 1'b0 : bv;
  assign eop1  = sel ? 1'b0 : e;
  assign d_in2 = sel ? d  : 1'b0;
  assign bv2   = sel ? bv : 1'b0;
  assign eop2  = sel ? e  : 1'b0;

  always #5 clk = ~clk;

  usb_rx_deserializer dut1 (
    .clk(clk), .n_rst(n_rst), .d_in(d_in1), .bit_valid(bv1), .eop(eop1),
    .rx_data(rx_data1), .rx_data_valid(rx_data_valid1), .rx_active(rx_active1),
    .rx_done(rx_done1), .rx_error(rx_error1), .rx_err_code(rx_err_code1),
    .rx_byte_cnt(rx_byte_cnt1)
  );

  usb_rx_deserializer #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .d_in(d_in2), .bit_valid(bv2), .eop(eop2),
    .rx_data(rx_data2), .rx_data_valid(rx_data_valid2), .rx_active(rx_active2),
    .rx_done(rx_done2), .rx_error(rx_error2), .rx_err_code(rx_err_code2),
    .rx_byte_cnt(rx_byte_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push(input logic s, input logic [1:0] kind, input logic [7:0] val);
    ev_t ev;
    ev.kind = kind;
    ev.val  = val;
    if (s) q2.push_back(ev);
    else   q1.push_back(ev);
  endtask

  task automatic mon_check(input int which, input logic [1:0] kind, input logic [7:0] val);
    ev_t ev;
    total++;
    if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
      $display("FAIL sb_unexpected dut%0d: got kind=%0d val=0x%02h, expected no event", which, kind, val);
      return;
    end
    ev = (which == 1) ? q1.pop_front() : q2.pop_front();
    if (ev.kind == kind && ev.val == val) passed++;
    else $display("FAIL sb_event dut%0d: got kind=%0d val=0x%02h, expected kind=%0d val=0x%02h",
                  which, kind, val, ev.kind, ev.val);
  endtask

  // Monitor: every output pulse must match the head of its queue
  always @(negedge clk) begin
    if (n_rst) begin
      if (rx_data_valid1) mon_check(1, c_EV_BYTE, rx_data1);
      if (rx_done1)       mon_check(1, c_EV_DONE, 8'h00);
      if (rx_error1)      mon_check(1, c_EV_ERR, {6'd0, rx_err_code1});
      if (rx_data_valid2) mon_check(2, c_EV_BYTE, rx_data2);
      if (rx_done2)       mon_check(2, c_EV_DONE, 8'h00);
      if (rx_error2)      mon_check(2, c_EV_ERR, {6'd0, rx_err_code2});
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    d  = b;
    bv = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop(input int nbits);
    @(posedge clk); #1;
    e = 1'b1;
    repeat (4 * nbits) @(posedge clk);
    #1;
    e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    check(name, q1.size() + q2.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; sel = 1'b0; d = 1'b0; bv = 1'b0; e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",   int'(rx_data1), 0);
    check("rst_valid",     int'(rx_data_valid1), 0);
    check("rst_active",    int'(rx_active1), 0);
    check("rst_done_err",  int'({rx_done1, rx_error1}), 0);
    check("rst_err_code",  int'(rx_err_code1), 0);
    check("rst_byte_cnt",  int'(rx_byte_cnt1), 0);
    n_rst = 1'b1;

    // 1: idle ones, SYNC, 0xA5, EOP
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_sync();
    check("t1_active", int'(rx_active1), 1);
    push(0, c_EV_BYTE, 8'hA5);
    send_byte(8'hA5);
    check("t1_byte_cnt", int'(rx_byte_cnt1), 1);
    push(0, c_EV_DONE, 8'h00);
    send_eop(2);
    check("t1_active_off", int'(rx_active1), 0);
    drain("t1_queue");

    // 2: 0xFF with stuffed 0 after five data ones, then 0x00
    send_sync();
    push(0, c_EV_BYTE, 8'hFF);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    push(0, c_EV_BYTE, 8'h00);
    send_byte(8'h00);
    push(0, c_EV_DONE, 8'h00);
    send_eop(2);
    check("t2_byte_cnt", int'(rx_byte_cnt1), 2);
    drain("t2_queue");

    // 3: seven ones after SYNC -> stuff error
    send_sync();
    push(0, c_EV_ERR, 8'h01);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("t3_active", int'(rx_active1), 0);
    check("t3_err_code", int'(rx_err_code1), 1);
    send_eop(1);
    drain("t3_queue");

    // 4: 0x3C + 3 bits then EOP -> misaligned
    send_sync();
    push(0, c_EV_BYTE, 8'h3C);
    send_byte(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    push(0, c_EV_ERR, 8'h02);
    send_eop(2);
    check("t4_err_code", int'(rx_err_code1), 2);
    check("t4_byte_cnt", int'(rx_byte_cnt1), 1);
    drain("t4_queue");

    // 5: MAX_BYTES=2 instance, three bytes -> overflow on third
    sel = 1'b1;
    send_sync();
    check("t5_active", int'(rx_active2), 1);
    push(1, c_EV_BYTE, 8'h11);
    send_byte(8'h11);
    push(1, c_EV_BYTE, 8'h22);
    send_byte(8'h22);
    push(1, c_EV_ERR, 8'h03);
    send_byte(8'h33);
    check("t5_byte_cnt", int'(rx_byte_cnt2), 2);
    check("t5_err_code", int'(rx_err_code2), 3);
    send_eop(2);
    drain("t5_queue");
    sel = 1'b0;

    // 6: reset after four data bits, then new packet 0x5A
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'b1 ^ i[0]);
    n_rst = 1'b0;
    #2;
    check("t6_rst_active", int'(rx_active1), 0);
    check("t6_rst_cnt", int'(rx_byte_cnt1), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_sync();
    push(0, c_EV_BYTE, 8'h5A);
    send_byte(8'h5A);
    push(0, c_EV_DONE, 8'h00);
    send_eop(2);
    check("t6_byte_cnt", int'(rx_byte_cnt1), 1);
    drain("t6_queue");

    // 7: bit_valid with eop at a byte boundary -> bit dropped, done
    send_sync();
    push(0, c_EV_BYTE, 8'hA5);
    send_byte(8'hA5);
    push(0, c_EV_DONE, 8'h00);
    @(posedge clk); #1;
    d = 1'b1; bv = 1'b1; e = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t7_byte_cnt", int'(rx_byte_cnt1), 1);
    drain("t7_queue");

    // 8: only two zeros before a 1 -> no SYNC
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      check("t8_active", int'(rx_active1), 0);
    end
    send_byte(8'hB6);
    check("t8_active_end", int'(rx_active1), 0);
    check("t8_byte_cnt", int'(rx_byte_cnt1), 1);
    drain("t8_queue");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive-side stage directly downstream of the USB NRZI decoder. Consumes the decoded bit stream (`d_in`), its per-bit strobe and the decoder's SE0/EOP flag. Detects SYNC, removes stuffed bits and assembles LSB-first bytes. Reports bytes, packet completion and framing/stuffing errors to the packet/PID layer.

## Interface
- `MAX_BYTES`, default 67: maximum bytes per packet after SYNC (PID + 64 data + CRC16); byte `MAX_BYTES+1` is an overflow error.
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `d_in` in 1: decoded bit from the NRZI decoder (`d_orig`).
- `bit_valid` in 1: one-cycle strobe marking `d_in` as a new bit. This is the decoder's `bit_rcvd` delayed one `clk`, so `d_in` is already the updated value.
- `eop` in 1: SE0 flag from the decoder (level).
- `rx_data` out 8: last completed byte; holds until the next byte.
- `rx_data_valid` out 1: one-cycle pulse, `rx_data` is new.
- `rx_active` out 1: high from SYNC detect until EOP, error, or reset.
- `rx_done` out 1: one-cycle pulse, packet ended cleanly on a byte boundary.
- `rx_error` out 1: one-cycle pulse, packet aborted.
- `rx_err_code` out 2: 01 stuff error, 10 misaligned EOP, 11 overflow. Holds until the next `rx_error`.
- `rx_byte_cnt` out 7: bytes delivered in the current or last packet. Cleared on SYNC detect.

## Operation
- States: IDLE, DATA, WAIT_EOP, WAIT_IDLE.
- IDLE:
  - `zero_cnt` (3 bits, saturates at 7) increments on each `bit_valid` with `d_in`=0.
  - On `bit_valid` with `d_in`=1:
    - if `zero_cnt` ≥ 3: SYNC found. Go to DATA; `ones_cnt`←1 (the SYNC's trailing 1 counts toward stuffing); `bit_cnt`←0; `rx_byte_cnt`←0.
    - otherwise `zero_cnt`←0.
  - `eop` high in IDLE: `zero_cnt`←0, no outputs.
- DATA, on `bit_valid` with `eop` low:
  - If `ones_cnt`==6, the bit is a stuffed bit:
    - `d_in`=0: discard it, `ones_cnt`←0.
    - `d_in`=1: stuff error (code 01), go to WAIT_EOP.
  - Otherwise, shift `d_in` into bit `bit_cnt` of the shift register (LSB first) and increment `bit_cnt`.
    - `ones_cnt` increments on 1 and clears on 0.
    - When `bit_cnt` reaches 8: load `rx_data`, pulse `rx_data_valid`, increment `rx_byte_cnt`, `bit_cnt`←0.
    - If that byte would make `rx_byte_cnt` exceed `MAX_BYTES`: no `rx_data_valid`; error code 11; go to WAIT_EOP.
- DATA, `eop` rising (level high):
  - `bit_cnt`==0 → pulse `rx_done`.
  - else → error code 10.
  - Either way go to WAIT_IDLE.
- Simultaneous `bit_valid` and `eop` high: `eop` wins, the bit is discarded.
- WAIT_EOP: ignore bits until `eop` is high, then go to WAIT_IDLE.
- WAIT_IDLE: ignore bits until `eop` is low, then go to IDLE with `zero_cnt`←0.
- `rx_active` = (state == DATA), registered.
- Widths: `bit_cnt` 4 bits (0..8), `ones_cnt` 3 bits, `zero_cnt` 3 bits, `rx_byte_cnt` 7 bits. No wrap is possible (overflow check precedes any wrap).
- Reset mid-packet: immediate return to IDLE. Partial byte is discarded; no pulse is generated on reset release.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_data_valid`=0, `rx_active`=0, `rx_done`=0, `rx_error`=0, `rx_err_code`=00, `rx_byte_cnt`=0.
  - Internal: state IDLE, all counters 0.
- All outputs are registered.
- `rx_data_valid` asserts the cycle after the `bit_valid` carrying a byte's 8th data bit.
- `rx_active` rises the cycle after the SYNC-terminating `bit_valid`.
- `rx_done`/`rx_error` pulse the cycle after the triggering event (`eop` sample or bad stuffed bit). `rx_active` falls in that same cycle.
- `rx_err_code` updates in the same cycle as `rx_error`.
- Strobes are at least 2 `clk` apart (8× oversampling). No back-to-back `bit_valid` handling is required, but the design must function if they do occur.

## Test plan
- IDLE 1s, then 0000000 1, then 0xA5 (bits 1,0,1,0,0,1,0,1), then `eop` high 2 bit times → `rx_active`=1; `rx_data`=0xA5 with one `rx_data_valid`; `rx_done` pulse; `rx_byte_cnt`=1.
- SYNC, then 0xFF sent as 1,1,1,1,1,[stuffed 0],1,1,1, then 0x00 and EOP → bytes 0xFF, 0x00; stuffed 0 removed (the trailing SYNC 1 counts, so the stuff falls after 5 data 1s); `rx_done`.
- SYNC, then seven consecutive 1s → `rx_error`, `rx_err_code`=01, no `rx_data_valid`; `eop` pulse returns the block to IDLE.
- SYNC, 0x3C, 3 extra bits, then `eop` → one byte 0x3C, then `rx_error` with code 10; no `rx_done`.
- `MAX_BYTES`=2: SYNC plus 3 bytes → two `rx_data_valid`, then `rx_error` code 11 on the 3rd byte.
- Assert `n_rst` after 4 data bits; release; send a new SYNC and 0x5A → no spurious pulses; 0x5A received.
- `bit_valid` and `eop` high in the same cycle at `bit_cnt`=0 → bit discarded; `rx_done` pulses.
- Only 2 leading zeros before the 1 → SYNC not detected; `rx_active` stays 0.
